score_display_scheduler: RTL and testbench



---
 rtl/score_display_scheduler_pkg.sv | 27 ++
 rtl/scan_tick_gen.sv | 29 ++
 rtl/score_display_scheduler.sv | 171 +++++++++++++++++
 tb/tb_score_display_scheduler.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/score_display_scheduler_pkg.sv
// Shared definitions for the score display scheduler: conversion FSM
// state encodings, display constants and digit/team index constants.
package score_display_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_SET_A   = 3'd0,
    ST_WAIT_A  = 3'd1,
    ST_LATCH_A = 3'd2,
    ST_SET_B   = 3'd3,
    ST_WAIT_B  = 3'd4,
    ST_LATCH_B = 3'd5
  } conv_state_e;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;
  localparam logic [6:0] SCORE_MAX   = 7'd99;

  // Bit positions within the one-hot digit select
  localparam int DIG_A_TENS = 0;
  localparam int DIG_A_ONES = 1;
  localparam int DIG_B_TENS = 2;
  localparam int DIG_B_ONES = 3;

  // Index into the held-digit arrays
  localparam int TEAM_A = 0;
  localparam int TEAM_B = 1;

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running 0..SCAN_DIV-1 counter; tick_o is high for the single cycle
// in which the counter sits at SCAN_DIV-1 (the cycle before it wraps).
module scan_tick_gen #(
  parameter int SCAN_DIV = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick_o = (cnt == CNT_LAST);

  // Count up and wrap to zero after the last slot cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (tick_o) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/score_display_scheduler.sv
// Time-shares one registered bin_to_decimal converter between the two team
// scores and scans the four held BCD digits onto a multiplexed display.
// Optional build macro: SCOREBOARD_LEADING_ZERO_BLANK_EN blanks a tens
// digit whose held value is zero (ones digits are never blanked).
import score_display_scheduler_pkg::*;

module score_display_scheduler #(
  parameter int CONV_LAT = 1,
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] score_a_i,
  input  logic [6:0] score_b_i,
  output logic [6:0] conv_bin_o,
  input  logic [3:0] conv_tens_i,
  input  logic [3:0] conv_ones_i,
  output logic [3:0] digit_o,
  output logic [3:0] digit_sel_o,
  output logic       update_o
);

  localparam int WAIT_W = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(CONV_LAT - 1);

  // Clamp a score so the converter only ever sees 0..99
  function automatic logic [6:0] sat99(input logic [6:0] v);
    return (v > SCORE_MAX) ? SCORE_MAX : v;
  endfunction

  // Display value for a tens digit; optionally suppresses a leading zero
  function automatic logic [3:0] tens_disp(input logic [3:0] t);
`ifdef SCOREBOARD_LEADING_ZERO_BLANK_EN
    return (t == 4'd0) ? DIGIT_BLANK : t;
`else
    return t;
`endif
  endfunction

  conv_state_e       state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_a, load_b, latch_a, latch_b, wait_run;

  logic [3:0]        held_tens [2];
  logic [3:0]        held_ones [2];

  logic              scan_tick;
  logic [3:0]        sel_nxt;
  logic [3:0]        digit_nxt;

  // Conversion FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_SET_A;
    end else begin
      state <= state_nxt;
    end
  end

  // Round-robin sequencing and per-state datapath strobes
  always_comb begin
    state_nxt = state;
    load_a    = 1'b0;
    load_b    = 1'b0;
    latch_a   = 1'b0;
    latch_b   = 1'b0;
    wait_run  = 1'b0;
    case (state)
      ST_SET_A: begin
        load_a    = 1'b1;
        state_nxt = ST_WAIT_A;
      end
      ST_WAIT_A: begin
        wait_run = 1'b1;
        if (wait_cnt == '0) state_nxt = ST_LATCH_A;
      end
      ST_LATCH_A: begin
        latch_a   = 1'b1;
        state_nxt = ST_SET_B;
      end
      ST_SET_B: begin
        load_b    = 1'b1;
        state_nxt = ST_WAIT_B;
      end
      ST_WAIT_B: begin
        wait_run = 1'b1;
        if (wait_cnt == '0) state_nxt = ST_LATCH_B;
      end
      ST_LATCH_B: begin
        latch_b   = 1'b1;
        state_nxt = ST_SET_A;
      end
      default: state_nxt = ST_SET_A;
    endcase
  end

  // Converter operand and latency down-counter, loaded on SET exit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      conv_bin_o <= '0;
      wait_cnt   <= '0;
    end else begin
      if (load_a) begin
        conv_bin_o <= sat99(score_a_i);
        wait_cnt   <= WAIT_INIT;
      end else if (load_b) begin
        conv_bin_o <= sat99(score_b_i);
        wait_cnt   <= WAIT_INIT;
      end else if (wait_run && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
    end
  end

  // Capture tens/ones together and flag a change against the old pair
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) begin
        held_tens[i] <= '0;
        held_ones[i] <= '0;
      end
      update_o <= 1'b0;
    end else begin
      update_o <= 1'b0;
      if (latch_a) begin
        held_tens[TEAM_A] <= conv_tens_i;
        held_ones[TEAM_A] <= conv_ones_i;
        update_o <= ({conv_tens_i, conv_ones_i} != {held_tens[TEAM_A], held_ones[TEAM_A]});
      end else if (latch_b) begin
        held_tens[TEAM_B] <= conv_tens_i;
        held_ones[TEAM_B] <= conv_ones_i;
        update_o <= ({conv_tens_i, conv_ones_i} != {held_tens[TEAM_B], held_ones[TEAM_B]});
      end
    end
  end

  scan_tick_gen #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_tick_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tick_o (scan_tick)
  );

  // Next selection and the digit it will show, sampled only at slot wrap
  always_comb begin
    sel_nxt   = {digit_sel_o[2:0], digit_sel_o[3]};
    digit_nxt = held_ones[TEAM_B];
    if (sel_nxt[DIG_A_TENS]) begin
      digit_nxt = tens_disp(held_tens[TEAM_A]);
    end else if (sel_nxt[DIG_A_ONES]) begin
      digit_nxt = held_ones[TEAM_A];
    end else if (sel_nxt[DIG_B_TENS]) begin
      digit_nxt = tens_disp(held_tens[TEAM_B]);
    end else if (sel_nxt[DIG_B_ONES]) begin
      digit_nxt = held_ones[TEAM_B];
    end
  end

  // Digit select and value change together, so a slot never glitches
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      digit_sel_o <= 4'b0001;
      digit_o     <= '0;
    end else if (scan_tick) begin
      digit_sel_o <= sel_nxt;
      digit_o     <= digit_nxt;
    end
  end

endmodule

// File: tb/tb_score_display_scheduler.sv
// Directed bench for score_display_scheduler with CONV_LAT=1, SCAN_DIV=4 and
// a behavioural registered bin_to_decimal converter attached.
module tb_score_display_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] score_a, score_b;
  logic [6:0] conv_bin;
  logic [3:0] conv_tens = '0;
  logic [3:0] conv_ones = '0;
  logic [3:0] digit;
  logic [3:0] digit_sel;
  logic       update;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

`ifdef SCOREBOARD_LEADING_ZERO_BLANK_EN
  localparam logic [3:0] EXP_ZERO_TENS = 4'hF;
`else
  localparam logic [3:0] EXP_ZERO_TENS = 4'h0;
`endif

  always #5 clk = ~clk;

  // Registered converter, one cycle of latency
  always_ff @(posedge clk) begin
    conv_tens <= 4'(conv_bin / 7'd10);
    conv_ones <= 4'(conv_bin % 7'd10);
  end

  score_display_scheduler #(
    .CONV_LAT (1),
    .SCAN_DIV (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .score_a_i   (score_a),
    .score_b_i   (score_b),
    .conv_bin_o  (conv_bin),
    .conv_tens_i (conv_tens),
    .conv_ones_i (conv_ones),
    .digit_o     (digit),
    .digit_sel_o (digit_sel),
    .update_o    (update)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    rst     = 1'b1;
    score_a = 7'd42;
    score_b = 7'd7;
    repeat (3) @(negedge clk);
    check_eq("rst_conv_bin", 32'(conv_bin), 32'd0);
    check_eq("rst_digit", 32'(digit), 32'd0);
    check_eq("rst_sel", 32'(digit_sel), 32'b0001);
    check_eq("rst_update", 32'(update), 32'd0);
    rst = 1'b0;
    cyc = 0;

    // Basic round: A=42, B=7
    check_eq("c0_conv_bin", 32'(conv_bin), 32'd0);
    run_to(1);
    check_eq("set_a_load", 32'(conv_bin), 32'd42);
    check_eq("c1_update", 32'(update), 32'd0);
    run_to(3);
    check_eq("upd_a_first", 32'(update), 32'd1);
    run_to(4);
    check_eq("c4_update", 32'(update), 32'd0);
    check_eq("set_b_load", 32'(conv_bin), 32'd7);
    check_eq("scan_sel_1", 32'(digit_sel), 32'b0010);
    check_eq("scan_a_ones", 32'(digit), 32'd2);
    run_to(6);
    check_eq("upd_b_first", 32'(update), 32'd1);
    run_to(8);
    check_eq("scan_sel_2", 32'(digit_sel), 32'b0100);
    check_eq("b_tens_zero", 32'(digit), 32'(EXP_ZERO_TENS));
    run_to(9);
    check_eq("no_upd_same_a", 32'(update), 32'd0);
    run_to(12);
    check_eq("no_upd_same_b", 32'(update), 32'd0);
    check_eq("scan_sel_3", 32'(digit_sel), 32'b1000);
    check_eq("scan_b_ones", 32'(digit), 32'd7);
    run_to(16);
    check_eq("scan_sel_wrap", 32'(digit_sel), 32'b0001);
    check_eq("scan_a_tens", 32'(digit), 32'd4);

    // Score change during WAIT_A only takes effect next round
    run_to(19);
    score_a = 7'd73;
    run_to(20);
    check_eq("c20_a_ones_old", 32'(digit), 32'd2);
    run_to(21);
    check_eq("mid_wait_no_upd", 32'(update), 32'd0);
    run_to(24);
    check_eq("c24_b_tens_zero", 32'(digit), 32'(EXP_ZERO_TENS));
    run_to(25);
    check_eq("next_round_load", 32'(conv_bin), 32'd73);
    run_to(27);
    check_eq("upd_a_73", 32'(update), 32'd1);
    run_to(28);
    check_eq("c28_b_ones", 32'(digit), 32'd7);
    run_to(32);
    check_eq("c32_a_tens_7", 32'(digit), 32'd7);
    run_to(36);
    check_eq("c36_a_ones_3", 32'(digit), 32'd3);

    // Saturation: 120 clamps to 99
    score_a = 7'd120;
    run_to(37);
    check_eq("sat_120", 32'(conv_bin), 32'd99);
    run_to(39);
    check_eq("upd_a_99", 32'(update), 32'd1);
    check_eq("no_glitch_mid_slot", 32'(digit), 32'd3);
    run_to(40);
    score_a = 7'd99;
    run_to(43);
    check_eq("load_99", 32'(conv_bin), 32'd99);
    run_to(45);
    check_eq("no_upd_99_same", 32'(update), 32'd0);
    run_to(48);
    check_eq("c48_a_tens_9", 32'(digit), 32'd9);
    run_to(52);
    check_eq("c52_sel", 32'(digit_sel), 32'b0010);
    check_eq("c52_a_ones_9", 32'(digit), 32'd9);

    // Asynchronous reset mid-WAIT_B, checked before any clock edge
    #2 rst = 1'b1;
    #1;
    check_eq("arst_conv_bin", 32'(conv_bin), 32'd0);
    check_eq("arst_digit", 32'(digit), 32'd0);
    check_eq("arst_sel", 32'(digit_sel), 32'b0001);
    check_eq("arst_update", 32'(update), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    check_eq("rel_conv_bin", 32'(conv_bin), 32'd0);
    run_to(1);
    check_eq("restart_set_a", 32'(conv_bin), 32'd99);
    run_to(3);
    check_eq("restart_upd_a", 32'(update), 32'd1);
    run_to(4);
    check_eq("restart_set_b", 32'(conv_bin), 32'd7);
    check_eq("restart_sel", 32'(digit_sel), 32'b0010);
    check_eq("restart_a_ones", 32'(digit), 32'd9);
    run_to(6);
    check_eq("restart_upd_b", 32'(update), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
